// File: rtl/pixel_scan_ctrl.sv
// Frame-scan sequencer: paces a raster of active/HBLANK/VBLANK ticks from the
// pixel timing generator's toggle flag and reports active pixel coordinates.
module pixel_scan_ctrl #(
    parameter int unsigned H_ACTIVE = 8,
    parameter int unsigned H_BLANK  = 2,
    parameter int unsigned V_ACTIVE = 4,
    parameter int unsigned V_BLANK  = 3,
    parameter int unsigned XW       = 8,
    parameter int unsigned YW       = 8
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          start,
    input  logic          cont,
    input  logic          abort,
    input  logic          flag_pixel,
    output logic          pix_en,
    output logic          pixel_strobe,
    output logic [XW-1:0] px_x,
    output logic [YW-1:0] px_y,
    output logic          hblank,
    output logic          vblank,
    output logic          busy,
    output logic          frame_done
);

    localparam int unsigned BMAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int unsigned BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

    localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE - 1);
    localparam logic [BW-1:0] HB_LAST = BW'(H_BLANK - 1);
    localparam logic [BW-1:0] VB_LAST = BW'(V_BLANK - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_ACTIVE,
        S_HBLANK,
        S_VBLANK,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic          flag_q;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          strobe_q, strobe_d;
    logic [XW-1:0] px_x_q, px_x_d;
    logic [YW-1:0] px_y_q, px_y_d;
    logic          tick;

    // One generator toggle in either direction is one pixel tick.
    assign tick = flag_pixel ^ flag_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= S_IDLE;
            flag_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            bcnt_q   <= '0;
            strobe_q <= 1'b0;
            px_x_q   <= '0;
            px_y_q   <= '0;
        end else begin
            state_q  <= state_d;
            flag_q   <= flag_pixel;
            x_q      <= x_d;
            y_q      <= y_d;
            bcnt_q   <= bcnt_d;
            strobe_q <= strobe_d;
            px_x_q   <= px_x_d;
            px_y_q   <= px_y_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        bcnt_d   = bcnt_q;
        strobe_d = 1'b0;
        px_x_d   = px_x_q;
        px_y_d   = px_y_q;

        // Abort preempts any tick handling in every busy state.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) state_d = S_ARM;
                end
                S_ARM: begin
                    x_d     = '0;
                    y_d     = '0;
                    bcnt_d  = '0;
                    state_d = S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (tick) begin
                        strobe_d = 1'b1;
                        px_x_d   = x_q;
                        px_y_d   = y_q;
                        if (x_q == X_LAST) begin
                            x_d     = '0;
                            bcnt_d  = '0;
                            state_d = S_HBLANK;
                        end else begin
                            x_d = x_q + XW'(1);
                        end
                    end
                end
                S_HBLANK: begin
                    if (tick) begin
                        if (bcnt_q != HB_LAST) begin
                            bcnt_d = bcnt_q + BW'(1);
                        end else if (y_q == Y_LAST) begin
                            y_d     = '0;
                            bcnt_d  = '0;
                            state_d = S_VBLANK;
                        end else begin
                            y_d     = y_q + YW'(1);
                            state_d = S_ACTIVE;
                        end
                    end
                end
                S_VBLANK: begin
                    if (tick) begin
                        if (bcnt_q == VB_LAST) state_d = S_DONE;
                        else                   bcnt_d  = bcnt_q + BW'(1);
                    end
                end
                S_DONE: begin
                    state_d = cont ? S_ARM : S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Moore decodes of the state register.
    assign pix_en     = (state_q == S_ARM) || (state_q == S_ACTIVE) ||
                        (state_q == S_HBLANK) || (state_q == S_VBLANK);
    assign busy       = (state_q != S_IDLE);
    assign hblank     = (state_q == S_HBLANK);
    assign vblank     = (state_q == S_VBLANK);
    assign frame_done = (state_q == S_DONE);

    assign pixel_strobe = strobe_q;
    assign px_x         = px_x_q;
    assign px_y         = px_y_q;

endmodule

// File: tb/tb_pixel_scan_ctrl.sv
// Scoreboard bench for pixel_scan_ctrl on a 4x2 raster (HB=2, VB=3) with a
// generator model toggling flag_pixel every 5 enabled cycles.
module tb_pixel_scan_ctrl;

    localparam int unsigned HA = 4;
    localparam int unsigned HB = 2;
    localparam int unsigned VA = 2;
    localparam int unsigned VB = 3;
    localparam int unsigned TICKS_PER_FRAME = VA * (HA + HB) + VB;

    logic       clk;
    logic       n_rst;
    logic       start;
    logic       cont;
    logic       abort;
    logic       flag_pixel;
    logic       pix_en;
    logic       pixel_strobe;
    logic [7:0] px_x;
    logic [7:0] px_y;
    logic       hblank;
    logic       vblank;
    logic       busy;
    logic       frame_done;

    pixel_scan_ctrl #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .XW(8), .YW(8)
    ) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .cont(cont), .abort(abort),
        .flag_pixel(flag_pixel), .pix_en(pix_en), .pixel_strobe(pixel_strobe),
        .px_x(px_x), .px_y(px_y), .hblank(hblank), .vblank(vblank),
        .busy(busy), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
    } pix_t;

    pix_t exp_q[$];
    int checks;
    int failures;
    int strobe_cnt;
    int done_cnt;

    // Generator model and per-step samples, all owned by the stimulus thread.
    int gen_cnt;
    int tick_cnt;
    int hb_ticks;
    int vb_ticks;
    int step_no;
    int last_tick_step;
    bit s_done, s_strobe, s_pix_en, s_busy, s_hblank;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic monitor();
        pix_t e;
        forever begin
            @(negedge clk);
            if (n_rst) begin
                if (pixel_strobe) begin
                    strobe_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_strobe actual=(%0d,%0d) required=none",
                                 px_x, px_y);
                    end else begin
                        e = exp_q.pop_front();
                        chk("px_x", int'(px_x), e.x);
                        chk("px_y", int'(px_y), e.y);
                    end
                end
                if (frame_done) done_cnt++;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        step_no++;
        s_done   = frame_done;
        s_strobe = pixel_strobe;
        s_pix_en = pix_en;
        s_busy   = busy;
        s_hblank = hblank;
        if (pix_en) begin
            gen_cnt++;
            if (gen_cnt == 5) begin
                gen_cnt        = 0;
                flag_pixel     = ~flag_pixel;
                tick_cnt++;
                last_tick_step = step_no;
                if (hblank) hb_ticks++;
                if (vblank) vb_ticks++;
            end
        end else begin
            gen_cnt = 0;
        end
    endtask

    task automatic push_frame();
        pix_t p;
        for (int y = 0; y < int'(VA); y++) begin
            for (int x = 0; x < int'(HA); x++) begin
                p.x = x;
                p.y = y;
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Single non-continuous frame, optionally with latency checks or a stray start.
    task automatic do_frame(input bit lat_chk, input bit mid_start);
        int  s0, d0;
        bit  found, lat_done, ms_done;
        s0 = strobe_cnt;
        d0 = done_cnt;
        tick_cnt = 0;
        hb_ticks = 0;
        vb_ticks = 0;
        found = 0;
        lat_done = 0;
        ms_done = 0;
        push_frame();
        pulse_start();
        for (int i = 0; i < 300 && !found; i++) begin
            step();
            if (lat_chk && !lat_done && tick_cnt == 1) begin
                lat_done = 1;
                chk("strobe_before_tick", int'(s_strobe), 0);
                step();
                chk("strobe_tick_plus1", int'(s_strobe), 1);
                step();
                chk("strobe_tick_plus2", int'(s_strobe), 0);
            end
            if (mid_start && !ms_done && tick_cnt == 2) begin
                ms_done = 1;
                pulse_start();
            end
            if (s_done) begin
                found = 1;
                chk("ticks_at_done", tick_cnt, int'(TICKS_PER_FRAME));
                chk("done_after_last_tick", step_no - last_tick_step, 1);
            end
        end
        chk("frame_done_seen", int'(found), 1);
        step();
        chk("pix_en_after_done", int'(s_pix_en), 0);
        chk("busy_after_done", int'(s_busy), 0);
        step();
        chk("strobes_in_frame", strobe_cnt - s0, int'(HA * VA));
        chk("done_pulses", done_cnt - d0, 1);
        chk("hblank_ticks", hb_ticks, int'(HB * VA));
        chk("vblank_ticks", vb_ticks, int'(VB));
    endtask

    initial begin
        int s0, d0, nd, clr_at, busy_low, q_left;
        bit hb_seen;
        checks = 0; failures = 0; strobe_cnt = 0; done_cnt = 0;
        gen_cnt = 0; tick_cnt = 0; hb_ticks = 0; vb_ticks = 0;
        step_no = 0; last_tick_step = 0;
        n_rst = 1'b0; start = 1'b0; cont = 1'b0; abort = 1'b0; flag_pixel = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        step(); step();
        chk("rst_pix_en", int'(pix_en), 0);
        chk("rst_strobe", int'(pixel_strobe), 0);
        chk("rst_px_x", int'(px_x), 0);
        chk("rst_px_y", int'(px_y), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_blank", int'({hblank, vblank}), 0);
        chk("rst_done", int'(frame_done), 0);
        n_rst = 1'b1;
        step(); step();

        // Plain frame with strobe latency
        do_frame(1'b1, 1'b0);

        // Toggles in IDLE are ignored
        s0 = strobe_cnt;
        for (int i = 0; i < 4; i++) begin
            flag_pixel = ~flag_pixel;
            step(); step(); step();
        end
        chk("idle_toggle_strobes", strobe_cnt - s0, 0);
        chk("idle_toggle_busy", int'(s_busy), 0);

        // Continuous mode: two back-to-back frames
        s0 = strobe_cnt;
        d0 = done_cnt;
        push_frame();
        push_frame();
        cont = 1'b1;
        pulse_start();
        nd = 0; clr_at = -1; busy_low = 0;
        for (int i = 0; i < 600 && nd < 2; i++) begin
            step();
            if (!s_busy) busy_low++;
            if (s_done) begin
                nd++;
                if (nd == 1) clr_at = step_no + 1;
            end
            if (step_no == clr_at) cont = 1'b0;
        end
        cont = 1'b0;
        chk("cont_two_dones_seen", nd, 2);
        chk("cont_busy_low_cycles", busy_low, 0);
        step(); step();
        chk("cont_idle_after", int'(s_busy), 0);
        chk("cont_strobes", strobe_cnt - s0, int'(2 * HA * VA));
        chk("cont_done_pulses", done_cnt - d0, 2);

        // Abort during HBLANK of line 0, then a full restart
        d0 = done_cnt;
        tick_cnt = 0;
        push_frame();
        pulse_start();
        hb_seen = 0;
        for (int i = 0; i < 200 && !hb_seen; i++) begin
            step();
            if (s_hblank) hb_seen = 1;
        end
        chk("abort_hblank_reached", int'(hb_seen), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_pix_en", int'(s_pix_en), 0);
        chk("abort_busy", int'(s_busy), 0);
        chk("abort_hblank", int'(s_hblank), 0);
        q_left = exp_q.size();
        chk("abort_pixels_left", q_left, int'(HA * (VA - 1)));
        exp_q.delete();
        for (int i = 0; i < 10; i++) step();
        chk("abort_no_done", done_cnt - d0, 0);
        do_frame(1'b0, 1'b0);

        // Stray start during ACTIVE is ignored
        do_frame(1'b0, 1'b1);

        // Asynchronous reset mid-ACTIVE
        d0 = done_cnt;
        tick_cnt = 0;
        push_frame();
        pulse_start();
        for (int i = 0; i < 100 && tick_cnt < 2; i++) step();
        step();
        chk("pre_rst_px_x", int'(px_x), 1);
        #2;
        n_rst = 1'b0;
        #1;
        chk("arst_pix_en", int'(pix_en), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_px_x", int'(px_x), 0);
        chk("arst_strobe_done", int'({pixel_strobe, frame_done}), 0);
        exp_q.delete();
        step(); step();
        n_rst = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chk("post_rst_busy", int'(s_busy), 0);
        chk("post_rst_pix_en", int'(s_pix_en), 0);
        chk("post_rst_no_done", done_cnt - d0, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_scan_ctrl.md
Name: pixel_scan_ctrl

Overview:
- Frame-scan sequencer for the pixel timing generator.
- Drives the generator's enable and detects each toggle of its flag output as one pixel tick.
- Walks a raster of active pixels, horizontal blanking and vertical blanking, and reports pixel coordinates to the downstream pixel datapath.
- Starts on a start pulse, supports continuous frames and abort, and signals frame completion.

Parameters:
- H_ACTIVE, 8, active pixel ticks per line (>=1)
- H_BLANK, 2, blanking ticks after each line (>=1)
- V_ACTIVE, 4, active lines per frame (>=1)
- V_BLANK, 3, blanking ticks after last line's HBLANK (>=1)
- XW, 8, width of px_x (must hold H_ACTIVE-1)
- YW, 8, width of px_y (must hold V_ACTIVE-1)

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- cont  in  1  sampled in DONE; 1 = re-arm immediately for the next frame
- abort  in  1  terminate scan; highest priority
- flag_pixel  in  1  toggle output of the pixel timing generator
- pix_en  out  1  enable to the pixel timing generator
- pixel_strobe  out  1  one-cycle pulse per active pixel
- px_x  out  XW  active pixel column, valid with pixel_strobe
- px_y  out  YW  active line index, valid with pixel_strobe
- hblank  out  1  high in HBLANK
- vblank  out  1  high in VBLANK
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse in DONE

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low on n_rst, clock named clk.
  - Reset state: IDLE, flag_q=0, px_x=0, px_y=0, bcnt=0.
  - Reset outputs: all outputs 0.
  - Reset mid-frame returns to IDLE immediately, with no frame_done.
- Tick detection:
  - flag_q <= flag_pixel every cycle, in all states.
  - tick = flag_pixel ^ flag_q, combinational, used only inside the FSM.
  - Toggles occurring while not in ACTIVE/HBLANK/VBLANK are ignored.
- Output decode:
  - pix_en, busy, hblank and vblank are Moore decodes of the state register only.
  - pixel_strobe, px_x and px_y are registered.
  - pixel_strobe is high in the cycle after the edge at which tick was sampled in ACTIVE; px_x/px_y hold that pixel's coordinates. Latency is one clock from the tick.
  - px_x/px_y hold their last values between strobes.
- States and transitions (abort=1 in any non-IDLE state -> IDLE next cycle, overriding everything):
  - IDLE: pix_en=0. start=1 -> ARM.
  - ARM (1 cycle): pix_en=1, clear x counter, y counter and bcnt -> ACTIVE. A tick in ARM is ignored.
  - ACTIVE: pix_en=1. On tick: strobe the current (x,y). If x==H_ACTIVE-1, set x<=0, bcnt<=0 -> HBLANK; else x<=x+1.
  - HBLANK: pix_en=1, hblank=1. On tick: if bcnt!=H_BLANK-1, bcnt++. Otherwise, if y==V_ACTIVE-1, set y<=0, bcnt<=0 -> VBLANK; else y<=y+1 -> ACTIVE.
  - VBLANK: pix_en=1, vblank=1. On tick: bcnt==V_BLANK-1 -> DONE, else bcnt++.
  - DONE (1 cycle): frame_done=1, pix_en=0. cont=1 -> ARM; else -> IDLE.
- Boundary conditions:
  - start while busy is ignored. start and abort together in IDLE: start wins, because abort has no effect in IDLE.
  - Exactly one tick is consumed per clock; the generator guarantees at least 2 cycles between toggles.
  - Total ticks per frame = V_ACTIVE*(H_ACTIVE+H_BLANK)+V_BLANK.
  - The x/y counters never exceed H_ACTIVE-1 / V_ACTIVE-1; there is no wrap beyond these bounds.

Test Plan:
- Reset mid-ACTIVE: drop n_rst asynchronously -> all outputs 0 without waiting for a clock edge; state IDLE after release; no frame_done.
- Full frame, H_ACTIVE=4, H_BLANK=2, V_ACTIVE=2, V_BLANK=3; bench toggles flag_pixel every 5 cycles while pix_en=1:
  - Exactly 8 pixel_strobes, coordinates (0,0)..(3,0),(0,1)..(3,1) in order.
  - hblank spans 2 ticks after each line; vblank spans 3 ticks.
  - frame_done pulses once, on the cycle after the 15th tick; pix_en=0 thereafter.
- Strobe latency: flag toggle sampled at edge N in ACTIVE -> pixel_strobe=1 exactly in cycle N+1, for one cycle.
- Continuous mode: cont=1 held -> DONE is followed by ARM, then a second identical 8-strobe frame; busy stays 1 throughout; exactly 2 frame_done pulses.
- Abort during HBLANK of line 0 -> IDLE next cycle, pix_en=0, no frame_done; a later start produces a full frame beginning at (0,0).
- Ignored inputs:
  - start pulsed during ACTIVE -> no restart; frame completes with 8 strobes.
  - flag_pixel toggled in IDLE -> no pixel_strobe.
